// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared definitions for the MEM stage.
//   mem_size_e : MemSize encodings (byte / half / word / dword)
//   lane_mask  : byte-lane enable pattern for an access size (unshifted)
//   align_mask : byte-offset bits that must be zero for an aligned access
//   extend     : truncate a right-aligned value to the access size, then
//                sign- or zero-extend it to 64 bits
package mips_mem_pkg;

   typedef enum logic [1:0] {
      MSZ_B = 2'b00,
      MSZ_H = 2'b01,
      MSZ_W = 2'b10,
      MSZ_D = 2'b11
   } mem_size_e;

   function automatic logic [7:0] lane_mask(input mem_size_e sz);
      case (sz)
         MSZ_B:   lane_mask = 8'h01;
         MSZ_H:   lane_mask = 8'h03;
         MSZ_W:   lane_mask = 8'h0F;
         default: lane_mask = 8'hFF;
      endcase
   endfunction

   function automatic logic [2:0] align_mask(input mem_size_e sz);
      case (sz)
         MSZ_B:   align_mask = 3'd0;
         MSZ_H:   align_mask = 3'd1;
         MSZ_W:   align_mask = 3'd3;
         default: align_mask = 3'd7;
      endcase
   endfunction

   function automatic logic [63:0] extend(input logic [63:0] d,
                                          input mem_size_e   sz,
                                          input logic        sgn);
      case (sz)
         MSZ_B:   extend = {{56{sgn & d[7]}},  d[7:0]};
         MSZ_H:   extend = {{48{sgn & d[15]}}, d[15:0]};
         MSZ_W:   extend = {{32{sgn & d[31]}}, d[31:0]};
         default: extend = d;
      endcase
   endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// byte_lane_ram: DEPTH x DATA_W RAM, synchronous write with one enable per
// byte lane, combinational (asynchronous) read.
//   clk_i    : write clock
//   we_i     : write enable (qualified per lane by be_i)
//   be_i     : byte-lane enables
//   addr_i   : word index
//   wdata_i  : write data (lane i taken from bits [8i+7:8i])
//   rdata_o  : word at addr_i
module byte_lane_ram #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 256,
  parameter     INIT_HEX = ""
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [DATA_W/8-1:0]      be_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < NB; i++) begin
      if (we_i && be_i[i]) mem[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
    end
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/data_mem_stage.sv
// data_mem_stage: MEM + WB stage. Byte-addressed little-endian data RAM,
// alignment check, load extension, MEM/WB pipeline register and WB mux.
//   Clk, Reset_n           : clock, async active-low reset
//   MemRead/MemWrite       : load / store this cycle (both = store)
//   MemSize, MemSigned     : access size, load sign-extension
//   MemtoReg               : WB selects load data (1) or AluResult (0)
//   RegWriteIn, WriteRegIn : register-file write request from EX/MEM
//   AluResult, StoreData   : byte address / bypass value, right-aligned store data
//   WBData, RegWriteOut, WriteRegOut, Misaligned : registered WB outputs
module data_mem_stage
   import mips_mem_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 256,
   parameter int REG_AW   = 5,
   parameter     INIT_HEX = ""
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [1:0]        MemSize,
   input  logic              MemSigned,
   input  logic              MemtoReg,
   input  logic              RegWriteIn,
   input  logic [REG_AW-1:0] WriteRegIn,
   input  logic [DATA_W-1:0] AluResult,
   input  logic [DATA_W-1:0] StoreData,
   output logic [DATA_W-1:0] WBData,
   output logic              RegWriteOut,
   output logic [REG_AW-1:0] WriteRegOut,
   output logic              Misaligned
);

   localparam int NB = DATA_W / 8;
   localparam int LB = $clog2(NB);
   localparam int AW = $clog2(DEPTH);

   mem_size_e         msz;
   logic [LB-1:0]     off;
   logic [AW-1:0]     idx;
   logic [7:0]        lm8;
   logic [2:0]        am3;
   logic              bad_align;
   logic              misaligned;
   logic              ram_we;
   logic [NB-1:0]     wmask;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic [DATA_W-1:0] shifted;
   logic [63:0]       ld64;
   logic [DATA_W-1:0] load_data;

   logic [DATA_W-1:0] wb_d, wb_q;
   logic              rw_d, rw_q;
   logic [REG_AW-1:0] wr_d, wr_q;
   logic              mis_d, mis_q;

   assign msz = mem_size_e'(MemSize);
   assign off = AluResult[LB-1:0];
   assign idx = AluResult[AW+LB-1:LB];
   assign lm8 = lane_mask(msz);
   assign am3 = align_mask(msz);

   // A dword access can never be legal on a 32-bit data path.
   assign bad_align  = (|(off & am3[LB-1:0])) || (msz == MSZ_D && DATA_W == 32);
   assign misaligned = (MemRead || MemWrite) && bad_align;

   // Gating with Reset_n drops a store whose edge falls inside reset.
   assign ram_we = MemWrite && !misaligned && Reset_n;
   assign wmask  = lm8[NB-1:0] << off;

   always_comb begin
      wdata = StoreData;
      case (msz)
         MSZ_B:   wdata = {NB{StoreData[7:0]}};
         MSZ_H:   wdata = {(NB/2){StoreData[15:0]}};
         MSZ_W:   wdata = {(NB/4){StoreData[31:0]}};
         default: wdata = StoreData;
      endcase
   end

   byte_lane_ram #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .INIT_HEX(INIT_HEX)
   ) u_ram (
      .clk_i  (Clk),
      .we_i   (ram_we),
      .be_i   (wmask),
      .addr_i (idx),
      .wdata_i(wdata),
      .rdata_o(rdata)
   );

   assign shifted   = rdata >> {off, 3'b000};
   assign ld64      = extend(64'(shifted), msz, MemSigned);
   assign load_data = ld64[DATA_W-1:0];

   always_comb begin
      wb_d  = MemtoReg ? '0 : AluResult;
      rw_d  = RegWriteIn;
      wr_d  = WriteRegIn;
      mis_d = 1'b0;
      if (misaligned) begin
         wb_d  = '0;
         rw_d  = 1'b0;
         mis_d = 1'b1;
      end else if (!MemWrite && MemRead && MemtoReg) begin
         wb_d = load_data;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         wb_q  <= '0;
         rw_q  <= 1'b0;
         wr_q  <= '0;
         mis_q <= 1'b0;
      end else begin
         wb_q  <= wb_d;
         rw_q  <= rw_d;
         wr_q  <= wr_d;
         mis_q <= mis_d;
      end
   end

   assign WBData      = wb_q;
   assign RegWriteOut = rw_q;
   assign WriteRegOut = wr_q;
   assign Misaligned  = mis_q;

endmodule

// File: tb/tb_data_mem_stage.sv
module tb_data_mem_stage;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        MemRead, MemWrite, MemSigned, MemtoReg, RegWriteIn;
   logic [1:0]  MemSize;
   logic [4:0]  WriteRegIn;
   logic [31:0] AluResult, StoreData;
   logic [31:0] WBData;
   logic        RegWriteOut;
   logic [4:0]  WriteRegOut;
   logic        Misaligned;

   int total = 0;
   int bad   = 0;

   always #5 Clk = ~Clk;

   data_mem_stage #(
      .DATA_W(32),
      .DEPTH (256),
      .REG_AW(5)
   ) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .MemSize    (MemSize),
      .MemSigned  (MemSigned),
      .MemtoReg   (MemtoReg),
      .RegWriteIn (RegWriteIn),
      .WriteRegIn (WriteRegIn),
      .AluResult  (AluResult),
      .StoreData  (StoreData),
      .WBData     (WBData),
      .RegWriteOut(RegWriteOut),
      .WriteRegOut(WriteRegOut),
      .Misaligned (Misaligned)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic m2r, input logic rw,
                        input logic [4:0] wreg, input logic [31:0] addr,
                        input logic [31:0] sd);
      MemRead = rd; MemWrite = wr; MemSize = sz; MemSigned = sg;
      MemtoReg = m2r; RegWriteIn = rw; WriteRegIn = wreg;
      AluResult = addr; StoreData = sd;
   endtask

   // drive inputs, take one edge, sample 1 time unit after it
   task automatic op(input logic rd, input logic wr, input logic [1:0] sz,
                     input logic sg, input logic m2r, input logic rw,
                     input logic [4:0] wreg, input logic [31:0] addr,
                     input logic [31:0] sd);
      drive(rd, wr, sz, sg, m2r, rw, wreg, addr, sd);
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Reset_n = 1'b0;
      drive(0, 0, 2'b00, 0, 0, 0, 5'd0, 32'h0, 32'h0);
      #12;
      check("reset_wb",  WBData, 32'h0);
      check("reset_rw",  {31'b0, RegWriteOut}, 32'h0);
      check("reset_wr",  {27'b0, WriteRegOut}, 32'h0);
      check("reset_mis", {31'b0, Misaligned}, 32'h0);
      @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);

      // 1: SW then LW
      op(0, 1, 2'b10, 0, 0, 0, 5'd0, 32'h08, 32'h12345678);
      check("sw_wb_alu", WBData, 32'h08);
      check("sw_rw",     {31'b0, RegWriteOut}, 32'h0);
      op(1, 0, 2'b10, 1, 1, 1, 5'd3, 32'h08, 32'h0);
      check("lw8_wb", WBData, 32'h12345678);
      check("lw8_rw", {31'b0, RegWriteOut}, 32'h1);
      check("lw8_wr", {27'b0, WriteRegOut}, 32'd3);

      // 2: byte loads and store
      op(1, 0, 2'b00, 1, 1, 1, 5'd4, 32'h09, 32'h0);
      check("lb9", WBData, 32'h00000056);
      op(0, 1, 2'b00, 0, 0, 0, 5'd0, 32'h0A, 32'h00000080);
      op(1, 0, 2'b00, 1, 1, 1, 5'd4, 32'h0A, 32'h0);
      check("lbA_s", WBData, 32'hFFFFFF80);
      op(1, 0, 2'b00, 0, 1, 1, 5'd4, 32'h0A, 32'h0);
      check("lbuA", WBData, 32'h00000080);

      // 3: half store and loads
      op(0, 1, 2'b01, 0, 0, 0, 5'd0, 32'h0A, 32'h0000BEEF);
      op(1, 0, 2'b10, 0, 1, 1, 5'd5, 32'h08, 32'h0);
      check("lw8_after_sh", WBData, 32'hBEEF5678);
      op(1, 0, 2'b01, 0, 1, 1, 5'd5, 32'h0A, 32'h0);
      check("lhuA", WBData, 32'h0000BEEF);
      op(1, 0, 2'b01, 1, 1, 1, 5'd5, 32'h0A, 32'h0);
      check("lhA_s", WBData, 32'hFFFFBEEF);

      // 4: misalignment
      op(1, 0, 2'b10, 0, 1, 1, 5'd6, 32'h06, 32'h0);
      check("lw6_mis", {31'b0, Misaligned}, 32'h1);
      check("lw6_rw",  {31'b0, RegWriteOut}, 32'h0);
      check("lw6_wb",  WBData, 32'h0);
      op(0, 1, 2'b10, 0, 0, 0, 5'd0, 32'h04, 32'h11223344);
      check("mis_clears", {31'b0, Misaligned}, 32'h0);
      op(0, 1, 2'b10, 0, 0, 0, 5'd0, 32'h05, 32'h0000DEAD);
      check("sw5_mis", {31'b0, Misaligned}, 32'h1);
      op(0, 1, 2'b01, 0, 0, 0, 5'd0, 32'h0B, 32'h00001111);
      check("shB_mis", {31'b0, Misaligned}, 32'h1);
      op(1, 0, 2'b10, 0, 1, 1, 5'd6, 32'h04, 32'h0);
      check("lw4_unchanged", WBData, 32'h11223344);
      op(1, 0, 2'b11, 0, 1, 1, 5'd6, 32'h00, 32'h0);
      check("ld_dword32_mis", {31'b0, Misaligned}, 32'h1);
      op(1, 0, 2'b10, 0, 1, 1, 5'd6, 32'h08, 32'h0);
      check("lw8_after_mis_sh", WBData, 32'hBEEF5678);

      // 5: ALU bypass, no-access and read+write corner cases
      op(0, 0, 2'b10, 0, 0, 1, 5'd7, 32'hCAFEF00D, 32'h0);
      check("alu_wb", WBData, 32'hCAFEF00D);
      check("alu_wr", {27'b0, WriteRegOut}, 32'd7);
      op(0, 0, 2'b10, 0, 1, 1, 5'd8, 32'hCAFEF00D, 32'h0);
      check("noacc_m2r_wb", WBData, 32'h0);
      op(1, 1, 2'b10, 0, 1, 1, 5'd9, 32'h20, 32'h5A5A5A5A);
      check("rdwr_wb", WBData, 32'h0);
      check("rdwr_rw", {31'b0, RegWriteOut}, 32'h1);
      op(0, 1, 2'b10, 0, 0, 0, 5'd0, 32'h20, 32'hA5A5A5A5);
      op(1, 0, 2'b10, 0, 1, 1, 5'd9, 32'h20, 32'h0);
      check("b2b_lw20", WBData, 32'hA5A5A5A5);

      // 6: reset in the middle of a store
      op(0, 1, 2'b10, 0, 0, 0, 5'd0, 32'h10, 32'h00000000);
      op(1, 0, 2'b10, 0, 1, 1, 5'd9, 32'h08, 32'h0);
      check("pre_rst_wb", WBData, 32'hBEEF5678);
      drive(0, 1, 2'b10, 0, 0, 1, 5'd10, 32'h10, 32'h00000001);
      @(negedge Clk);
      Reset_n = 1'b0;
      #1;
      check("rst_async_wb", WBData, 32'h0);
      check("rst_async_rw", {31'b0, RegWriteOut}, 32'h0);
      check("rst_async_wr", {27'b0, WriteRegOut}, 32'h0);
      @(posedge Clk);
      #1;
      check("rst_hold_wb", WBData, 32'h0);
      Reset_n = 1'b1;
      op(1, 0, 2'b10, 0, 1, 1, 5'd11, 32'h10, 32'h0);
      check("lw10_dropped", WBData, 32'h0);
      op(1, 0, 2'b10, 0, 1, 1, 5'd11, 32'h408, 32'h0);
      check("lw408_wrap", WBData, 32'hBEEF5678);
      check("lw408_wr", {27'b0, WriteRegOut}, 32'd11);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
